bram_frame_streamer: RTL and testbench
======================================

# bram_frame_streamer

Sequencer that streams a configurable W×H 8-bit image frame out of the single-port image BRAM into the write side of the async FIFO that feeds the Sobel stage. It owns the BRAM read port and the FIFO write port. It tolerates the BRAM's one-cycle read latency and FIFO back-pressure through an internal skid buffer, so no byte is ever lost or duplicated. It reports frame progress through busy/done/error status and per-pixel sideband markers.

## Interface
- ADDR_W, 13, BRAM address width
- DATA_W, 8, pixel width
- DIM_W, 8, width/height field width
- BASE_ADDR, 0, BRAM address of pixel (0,0)
- SKID_DEPTH, 4, skid-buffer entries; also the max outstanding reads
- clk_100mhz  in  1  single clock for BRAM read and FIFO write domain
- reset_n  in  1  asynchronous active-low reset
- start  in  1  sampled in IDLE only; latches cfg and begins a frame
- abort  in  1  terminates the frame; returns to IDLE next cycle
- cfg_width  in  DIM_W  pixels per row
- cfg_height  in  DIM_W  rows per frame
- fifo_rst_busy  in  1  FIFO wr_rst_busy; blocks writes while high
- fifo_full  in  1  FIFO full flag
- bram_en  out  1  BRAM read enable (wea is tied 0 at top)
- bram_addr  out  ADDR_W  read address
- bram_data  in  DATA_W  BRAM douta; valid the cycle after bram_en
- fifo_din  out  DATA_W  byte to FIFO
- fifo_wr_en  out  1  FIFO write strobe
- sof, eol, eof  out  1 each  qualified by fifo_wr_en: first pixel of frame, last pixel of row, last pixel of frame
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse when the last byte is written
- err_cfg  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, WAIT_RST, STREAM, DRAIN, DONE.
- **IDLE**:
  - On start=1, compute N = cfg_width*cfg_height.
  - If width=0, height=0, or BASE_ADDR+N > 2^ADDR_W: pulse err_cfg and stay in IDLE.
  - Otherwise latch cfg, clear counters, go to WAIT_RST.
- **WAIT_RST**: hold while fifo_rst_busy=1, then go to STREAM.
- **STREAM**:
  - Issue reads at BASE_ADDR+idx, idx = 0..N-1, in linear order.
  - Track col and row counters; col wraps at width-1, row increments on wrap.
  - "Outstanding" = reads issued but not yet written to the FIFO.
  - Issue a read only when outstanding < SKID_DEPTH.
  - After the read of idx=N-1 is issued, go to DRAIN.
- **DRAIN**: wait until outstanding = 0, then go to DONE.
- **DONE**: pulse done, go to IDLE.
- Read data is captured into the skid FIFO on the cycle after bram_en=1.
- fifo_wr_en = skid_nonempty & ~fifo_full & ~fifo_rst_busy. This is combinational on registered buffer state.
- fifo_din = skid head.
- Sideband markers (sof/eol/eof) are stored per entry alongside the data.
- Skid buffer never overflows: the outstanding limit guarantees it.
- start while busy is ignored.
- abort in any non-IDLE state:
  - next state is IDLE;
  - bram_en drops, skid is flushed, in-flight data is discarded;
  - no done pulse.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.

## Timing
- Reset values: bram_en=0, bram_addr=0, fifo_din=0, fifo_wr_en=0, sof=eol=eof=0, busy=0, done=0, err_cfg=0, state IDLE.
- With start sampled at edge E0 and fifo_rst_busy=0, the sequence is:
  - busy is high after E0;
  - bram_en/bram_addr are registered and first high after E1;
  - data is captured at E3;
  - first fifo_wr_en is high after E3.
- Throughput: 1 byte/cycle sustained while fifo_full=0.
- fifo_full asserted: writes stop the same cycle. Reads stop once outstanding reaches SKID_DEPTH. Resume is immediate on deassert.
- done is high in the cycle after the final fifo_wr_en. busy falls one cycle after done.
- err_cfg is high in the cycle after the rejecting edge.

## Test plan
- width=4, height=3, BRAM[i]=i, FIFO never full:
  - exactly 12 writes of 0x00..0x0B on consecutive cycles;
  - sof on byte 0; eol on bytes 3, 7, 11; eof on byte 11;
  - done once.
- Same frame, fifo_full held high for 10 cycles starting after write 2:
  - ≤ SKID_DEPTH reads outstanding during the stall;
  - output sequence is unchanged, with no gaps or duplicates after release.
- Rejected configurations each give err_cfg pulse, busy stays 0, no bram_en:
  - width=0;
  - height=0;
  - width=128, height=65 (8320 > 8192).
- fifo_rst_busy high for 20 cycles at start: bram_en stays 0 until it drops, then the normal frame follows.
- abort after 5 writes of a 64×128 frame: bram_en and fifo_wr_en are 0 from the next cycle, no done; a subsequent start streams a full frame from address 0.
- reset_n asserted mid-STREAM: all outputs go to reset values asynchronously; after release, start restarts the frame cleanly.

Source files
------------

// File: rtl/bram_frame_streamer.sv
// Streams a W x H frame out of the image BRAM into the Sobel input FIFO.
// Read latency and FIFO back-pressure are absorbed by a small skid buffer.
module bram_frame_streamer #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int DIM_W      = 8,
    parameter int BASE_ADDR  = 0,
    parameter int SKID_DEPTH = 4
) (
    input  logic              clk_100mhz_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DIM_W-1:0]  cfg_width_i,
    input  logic [DIM_W-1:0]  cfg_height_i,
    input  logic              fifo_rst_busy_i,
    input  logic              fifo_full_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [DATA_W-1:0] bram_data_i,
    output logic [DATA_W-1:0] fifo_din_o,
    output logic              fifo_wr_en_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_cfg_o
);

    localparam int N_W   = 2 * DIM_W;
    localparam int CHK_W = ((N_W > ADDR_W) ? N_W : ADDR_W) + 2;
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int ENT_W = DATA_W + 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RST = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              err_q, err_d;
    logic [DIM_W-1:0]  w_q, h_q;
    logic [N_W-1:0]    n_q;
    logic [N_W-1:0]    idx_q;
    logic [DIM_W-1:0]  col_q, row_q;

    logic              bram_en_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [2:0]        sb1_q;
    logic              rd_vld_q;
    logic [2:0]        sb2_q;

    logic [ENT_W-1:0]  skid_mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  skid_cnt_q, skid_cnt_d;
    logic [CNT_W-1:0]  out_q, out_d;

    logic [N_W-1:0]    cfg_n;
    logic              cfg_ok;
    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              flush;
    logic              push;
    logic              wr_fire;
    logic              col_wrap;
    logic [ENT_W-1:0]  skid_head;

    assign cfg_n  = N_W'(cfg_width_i) * N_W'(cfg_height_i);
    assign cfg_ok = (cfg_width_i != '0) && (cfg_height_i != '0) &&
                    ((CHK_W'(BASE_ADDR) + CHK_W'(cfg_n)) <= (CHK_W'(1) << ADDR_W));

    assign accept = (state_q == S_IDLE) && start_i && !abort_i && cfg_ok;
    assign flush  = abort_i && (state_q != S_IDLE);

    // The first read goes out on the WAIT_RST->STREAM edge so bram_en leads by one cycle only.
    assign issue = !abort_i && (out_q < CNT_W'(SKID_DEPTH)) &&
                   (((state_q == S_WAIT_RST) && !fifo_rst_busy_i) || (state_q == S_STREAM));
    assign last_issue = issue && (idx_q == n_q - N_W'(1));
    assign col_wrap   = (col_q == w_q - DIM_W'(1));

    assign skid_head = skid_mem_q[rd_ptr_q];
    assign wr_fire   = (skid_cnt_q != '0) && !fifo_full_i && !fifo_rst_busy_i;
    assign push      = rd_vld_q && !flush;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if (cfg_ok) state_d = S_WAIT_RST;
                    else        err_d   = 1'b1;
                end
            end
            S_WAIT_RST: begin
                if (!fifo_rst_busy_i && issue) state_d = last_issue ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                if (last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_d == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        out_d = out_q;
        if (flush) out_d = '0;
        else       out_d = out_q + CNT_W'(issue) - CNT_W'(wr_fire);
    end

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        if (flush) skid_cnt_d = '0;
        else       skid_cnt_d = skid_cnt_q + CNT_W'(push) - CNT_W'(wr_fire);
    end

    always_ff @(posedge clk_100mhz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            out_q   <= out_d;
            if (accept) begin
                w_q   <= cfg_width_i;
                h_q   <= cfg_height_i;
                n_q   <= cfg_n;
                idx_q <= '0;
                col_q <= '0;
                row_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + N_W'(1);
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
            end
        end
    end

    // Sideband travels with the read through the two-stage BRAM latency pipeline.
    always_ff @(posedge clk_100mhz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            sb1_q       <= '0;
            rd_vld_q    <= 1'b0;
            sb2_q       <= '0;
        end else begin
            bram_en_q <= issue;
            if (issue) begin
                bram_addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                sb1_q       <= {(idx_q == '0), col_wrap, col_wrap && (row_q == h_q - DIM_W'(1))};
            end
            rd_vld_q <= bram_en_q && !flush;
            sb2_q    <= sb1_q;
        end
    end

    always_ff @(posedge clk_100mhz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SKID_DEPTH; i++) skid_mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            skid_cnt_q <= '0;
        end else begin
            skid_cnt_q <= skid_cnt_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    skid_mem_q[wr_ptr_q] <= {bram_data_i, sb2_q};
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (wr_fire) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign bram_en_o    = bram_en_q;
    assign bram_addr_o  = bram_addr_q;
    assign fifo_din_o   = skid_head[ENT_W-1:3];
    assign fifo_wr_en_o = wr_fire;
    assign sof_o        = wr_fire && skid_head[2];
    assign eol_o        = wr_fire && skid_head[1];
    assign eof_o        = wr_fire && skid_head[0];
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_cfg_o    = err_q;

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Directed bench for bram_frame_streamer: BRAM model, write scoreboard, status checks.
module tb_bram_frame_streamer;

    localparam int SKID_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, fifo_rst_busy, fifo_full;
    logic [7:0]  cfg_width, cfg_height;
    logic        bram_en;
    logic [12:0] bram_addr;
    logic [7:0]  bram_data = 8'h00;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en, sof, eol, eof, busy, done, err_cfg;

    int checks = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    int wr_count, rd_count, max_out, done_count, eof_cyc, done_cyc, first_wr_cyc, last_wr_cyc;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM holds i at address i (mod 256), one-cycle read latency.
    always @(posedge clk) if (bram_en) bram_data <= bram_addr[7:0];

    bram_frame_streamer dut (
        .clk_100mhz_i   (clk),
        .reset_n_i      (reset_n),
        .start_i        (start),
        .abort_i        (abort),
        .cfg_width_i    (cfg_width),
        .cfg_height_i   (cfg_height),
        .fifo_rst_busy_i(fifo_rst_busy),
        .fifo_full_i    (fifo_full),
        .bram_en_o      (bram_en),
        .bram_addr_o    (bram_addr),
        .bram_data_i    (bram_data),
        .fifo_din_o     (fifo_din),
        .fifo_wr_en_o   (fifo_wr_en),
        .sof_o          (sof),
        .eol_o          (eol),
        .eof_o          (eof),
        .busy_o         (busy),
        .done_o         (done),
        .err_cfg_o      (err_cfg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_counters();
        wr_count = 0; rd_count = 0; max_out = 0; done_count = 0;
        eof_cyc = -1; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    endtask

    task automatic push_frame(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                int idx;
                logic [7:0] d;
                idx = r * w + c;
                d = 8'(idx);
                exp_q.push_back({d, (idx == 0), (c == w - 1), (c == w - 1) && (r == h - 1)});
            end
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_width = 8'(w);
        cfg_height = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (wr_count < n && k < budget) begin tick(); k++; end
        check("write_count_reached", (wr_count >= n), 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin tick(); k++; end
        check("done_seen", done, 1);
        tick();
        check("busy_after_done", busy, 0);
    endtask

    // Write monitor: pops the scoreboard on every FIFO write.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bram_en === 1'b1) rd_count++;
            if (fifo_wr_en === 1'b1) begin
                check("sb_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("wr_data_markers", {fifo_din, sof, eol, eof}, exp_q.pop_front());
                if (eof === 1'b1) eof_cyc = cyc;
                wr_count++;
                if (wr_count == 1) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
            end
            if (rd_count - wr_count > max_out) max_out = rd_count - wr_count;
            if (done === 1'b1) begin done_count++; done_cyc = cyc; end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rej_w[3] = '{0, 5, 128};
        int rej_h[3] = '{3, 0, 65};
        int w_after, r_after;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; fifo_rst_busy = 1'b0; fifo_full = 1'b0;
        cfg_width = 8'd0; cfg_height = 8'd0;
        reset_counters();
        repeat (3) tick();
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_fifo_din", fifo_din, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_markers", {sof, eol, eof}, 0);
        check("rst_status", {busy, done, err_cfg}, 0);
        reset_n = 1'b1;
        tick();

        // Basic 4x3 frame with latency checks.
        reset_counters();
        push_frame(4, 3);
        start_frame(4, 3);
        check("t1_busy_after_e0", busy, 1);
        check("t1_bram_en_after_e0", bram_en, 0);
        tick();
        check("t1_bram_en_after_e1", bram_en, 1);
        check("t1_bram_addr_after_e1", bram_addr, 0);
        tick();
        check("t1_wr_en_after_e2", fifo_wr_en, 0);
        tick();
        check("t1_wr_en_after_e3", fifo_wr_en, 1);
        wait_done(100);
        check("t1_write_total", wr_count, 12);
        check("t1_write_span", last_wr_cyc - first_wr_cyc, 11);
        check("t1_done_count", done_count, 1);
        check("t1_done_after_eof", done_cyc, eof_cyc + 1);
        check("t1_sb_empty", exp_q.size(), 0);

        // Back-pressure stall after the third write.
        reset_counters();
        push_frame(4, 3);
        start_frame(4, 3);
        wait_writes(3, 50);
        fifo_full = 1'b1;
        repeat (10) tick();
        check("t2_no_write_in_stall", wr_count, 3);
        check("t2_outstanding_bound", (max_out <= SKID_DEPTH), 1);
        check("t2_reads_stalled", rd_count, 3 + SKID_DEPTH);
        fifo_full = 1'b0;
        wait_done(100);
        check("t2_write_total", wr_count, 12);
        check("t2_done_count", done_count, 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // Rejected configurations.
        for (int i = 0; i < 3; i++) begin
            reset_counters();
            start_frame(rej_w[i], rej_h[i]);
            check("t3_err_pulse", err_cfg, 1);
            check("t3_busy_low", busy, 0);
            tick();
            check("t3_err_cleared", err_cfg, 0);
            check("t3_busy_still_low", busy, 0);
            check("t3_no_reads", rd_count, 0);
        end

        // FIFO still in reset when the frame starts.
        reset_counters();
        push_frame(4, 3);
        fifo_rst_busy = 1'b1;
        start_frame(4, 3);
        repeat (19) tick();
        check("t4_no_reads_in_rst", rd_count, 0);
        check("t4_busy_in_rst", busy, 1);
        fifo_rst_busy = 1'b0;
        wait_done(100);
        check("t4_write_total", wr_count, 12);
        check("t4_sb_empty", exp_q.size(), 0);

        // Abort a full-size 64x128 frame after five writes.
        reset_counters();
        push_frame(64, 128);
        start_frame(64, 128);
        check("t5_boundary_accepted", busy, 1);
        wait_writes(5, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_bram_en_off", bram_en, 0);
        check("t5_wr_en_off", fifo_wr_en, 0);
        check("t5_busy_off", busy, 0);
        w_after = wr_count;
        r_after = rd_count;
        repeat (5) tick();
        check("t5_no_more_writes", wr_count, w_after);
        check("t5_no_more_reads", rd_count, r_after);
        check("t5_no_done", done_count, 0);
        exp_q.delete();

        reset_counters();
        push_frame(8, 2);
        start_frame(8, 2);
        tick();
        check("t5_restart_addr", bram_addr, 0);
        check("t5_restart_en", bram_en, 1);
        wait_done(100);
        check("t5_restart_writes", wr_count, 16);
        check("t5_restart_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream.
        reset_counters();
        push_frame(4, 3);
        start_frame(4, 3);
        wait_writes(3, 50);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_bram_en", bram_en, 0);
        check("t6_async_wr_en", fifo_wr_en, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_din_addr", {fifo_din, bram_addr}, 0);
        check("t6_async_markers", {sof, eol, eof, done, err_cfg}, 0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        reset_counters();
        push_frame(4, 3);
        start_frame(4, 3);
        wait_done(100);
        check("t6_restart_writes", wr_count, 12);
        check("t6_restart_done", done_count, 1);
        check("t6_restart_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
